// File: rtl/neuron_pkg.sv
// Shared definitions for the sequential neuron family: FSM states and default widths.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        LOSS
    } state_t;

    localparam int N_IN_DEF = 8;
    localparam int X_W_DEF  = 10;
    localparam int W_W_DEF  = 8;
    localparam int T_W_DEF  = 4;

endpackage

// File: rtl/sq_err.sv
// Combinational squared error between the accumulated dot product and the target,
// plus the all-zero detection used to flag a trivially converged pass.
module sq_err #(
    parameter int ACC_W = 21,
    parameter int T_W   = 4,
    parameter int L_W   = 2 * (ACC_W + 1)
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [T_W-1:0]   target,
    output logic [L_W-1:0]   loss,
    output logic             zero_end
);

    logic [ACC_W:0]          target_ext;
    logic signed [ACC_W:0]   diff;
    logic signed [L_W-1:0]   diff_ext;
    logic signed [L_W-1:0]   sq;

    assign target_ext = {{(ACC_W + 1 - T_W){1'b0}}, target};
    assign diff       = $signed({1'b0, acc}) - $signed(target_ext);

    // Widen before squaring so a negative difference squares to its true magnitude.
    assign diff_ext = diff;
    assign sq       = diff_ext * diff_ext;

    assign zero_end = (acc == '0) && (target == '0);
    assign loss     = zero_end ? '0 : $unsigned(sq);

endmodule

// File: rtl/output_neuron_seq.sv
// Time-multiplexed output neuron: one shared multiplier accumulates the dot product
// over N_IN cycles, then the squared error is registered with a done pulse.
module output_neuron_seq
    import neuron_pkg::*;
#(
    parameter int N_IN = N_IN_DEF,
    parameter int X_W  = X_W_DEF,
    parameter int W_W  = W_W_DEF,
    parameter int T_W  = T_W_DEF,
    localparam int ACC_W = X_W + W_W + $clog2(N_IN),
    localparam int L_W   = 2 * (ACC_W + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  clear_i,
    input  logic [N_IN*X_W-1:0]   x_i,
    input  logic [N_IN*W_W-1:0]   w_i,
    input  logic [T_W-1:0]        target_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ACC_W-1:0]      final_o,
    output logic [L_W-1:0]        loss_o,
    output logic                  zero_end_o,
    output logic [N_IN*W_W-1:0]   weights_o
);

    localparam int IDX_W = $clog2(N_IN);

    state_t               state;
    logic [N_IN*X_W-1:0]  x_q;
    logic [N_IN*W_W-1:0]  w_q;
    logic [T_W-1:0]       target_q;
    logic [ACC_W-1:0]     acc;
    logic [IDX_W-1:0]     idx;
    logic [X_W+W_W-1:0]   prod;
    logic [L_W-1:0]       loss_c;
    logic                 zero_end_c;

    // Single shared multiplier, operand selected by the running index.
    assign prod = x_q[idx*X_W +: X_W] * w_q[idx*W_W +: W_W];

    sq_err #(
        .ACC_W (ACC_W),
        .T_W   (T_W),
        .L_W   (L_W)
    ) u_sq_err (
        .acc      (acc),
        .target   (target_q),
        .loss     (loss_c),
        .zero_end (zero_end_c)
    );

    // Operands are captured at start so the inputs are free to change during a pass.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            x_q        <= '0;
            w_q        <= '0;
            target_q   <= '0;
            acc        <= '0;
            idx        <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            final_o    <= '0;
            loss_o     <= '0;
            zero_end_o <= 1'b0;
            weights_o  <= '0;
        end else if (clear_i) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            final_o    <= '0;
            loss_o     <= '0;
            zero_end_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        x_q       <= x_i;
                        w_q       <= w_i;
                        target_q  <= target_i;
                        weights_o <= w_i;
                        acc       <= '0;
                        idx       <= '0;
                        busy_o    <= 1'b1;
                        state     <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    idx <= idx + 1'b1;
                    if (idx == IDX_W'(N_IN - 1)) begin
                        state <= LOSS;
                    end
                end
                LOSS: begin
                    final_o    <= acc;
                    loss_o     <= loss_c;
                    zero_end_o <= zero_end_c;
                    done_o     <= 1'b1;
                    busy_o     <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_neuron_seq.sv
// Directed bench for output_neuron_seq at the default size and at N_IN=4.
module tb_output_neuron_seq;

    logic clk = 1'b0;
    logic rst_n;

    logic        start8, clear8, busy8, done8, ze8;
    logic [79:0] x8;
    logic [63:0] w8, weights8;
    logic [3:0]  t8;
    logic [20:0] final8;
    logic [43:0] loss8;

    logic        start4, clear4, busy4, done4, ze4;
    logic [39:0] x4;
    logic [31:0] w4, weights4;
    logic [3:0]  t4;
    logic [19:0] final4;
    logic [41:0] loss4;

    int cmp_count = 0;
    int err_count = 0;
    int pass_cycles;
    int busy_cycles;

    always #5 clk = ~clk;

    output_neuron_seq dut8 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start8), .clear_i(clear8),
        .x_i(x8), .w_i(w8), .target_i(t8), .busy_o(busy8), .done_o(done8),
        .final_o(final8), .loss_o(loss8), .zero_end_o(ze8), .weights_o(weights8)
    );

    output_neuron_seq #(.N_IN(4)) dut4 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start4), .clear_i(clear4),
        .x_i(x4), .w_i(w4), .target_i(t4), .busy_o(busy4), .done_o(done4),
        .final_o(final4), .loss_o(loss4), .zero_end_o(ze4), .weights_o(weights4)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        cmp_count++;
        if (got !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Starts a pass on one DUT, optionally holding start high into MAC, and waits for done.
    task automatic applyStimulus(input bit use4, input logic [79:0] xv, input logic [63:0] wv,
                                 input logic [3:0] tv, input int hold);
        @(negedge clk);
        if (use4) begin
            x4 = xv[39:0]; w4 = wv[31:0]; t4 = tv; start4 = 1'b1;
        end else begin
            x8 = xv; w8 = wv; t8 = tv; start8 = 1'b1;
        end
        @(negedge clk);
        pass_cycles = 0;
        busy_cycles = 0;
        while (!(use4 ? done4 : done8) && pass_cycles < 40) begin
            start4 = use4 && (pass_cycles < hold);
            start8 = !use4 && (pass_cycles < hold);
            if (use4 ? busy4 : busy8) busy_cycles++;
            @(negedge clk);
            pass_cycles++;
        end
        start4 = 1'b0;
        start8 = 1'b0;
        checkOutput("done_seen", 64'(use4 ? done4 : done8), 64'd1);
    endtask

    logic [79:0] xv;
    logic [63:0] wv;
    logic [63:0] fexp;
    int extra;
    int cnt;

    initial begin
        rst_n = 1'b0;
        start8 = 1'b0; clear8 = 1'b0; x8 = '0; w8 = '0; t8 = '0;
        start4 = 1'b0; clear4 = 1'b0; x4 = '0; w4 = '0; t4 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_final", 64'(final8), 64'd0);
        checkOutput("rst_loss", 64'(loss8), 64'd0);
        checkOutput("rst_zero_end", 64'(ze8), 64'd0);
        checkOutput("rst_done", 64'(done8), 64'd0);
        checkOutput("rst_busy", 64'(busy8), 64'd0);
        checkOutput("rst_weights", weights8, 64'd0);
        checkOutput("rst_final4", 64'(final4), 64'd0);

        for (int k = 0; k < 8; k++) begin
            xv[k*10 +: 10] = 10'd1;
            wv[k*8 +: 8]   = 8'd2;
        end
        applyStimulus(1'b0, xv, wv, 4'd3, 0);
        checkOutput("dflt_latency", 64'(pass_cycles), 64'd9);
        checkOutput("dflt_busy_len", 64'(busy_cycles), 64'd9);
        checkOutput("dflt_busy_done", 64'(busy8), 64'd0);
        checkOutput("dflt_final", 64'(final8), 64'd16);
        checkOutput("dflt_loss", 64'(loss8), 64'd169);
        checkOutput("dflt_zero_end", 64'(ze8), 64'd0);
        checkOutput("dflt_weights", weights8, wv);
        @(negedge clk);
        checkOutput("dflt_done_pulse", 64'(done8), 64'd0);
        checkOutput("dflt_hold_final", 64'(final8), 64'd16);

        applyStimulus(1'b0, 80'd0, 64'h0123_4567_89AB_CDEF, 4'd0, 0);
        checkOutput("zero_final", 64'(final8), 64'd0);
        checkOutput("zero_loss", 64'(loss8), 64'd0);
        checkOutput("zero_zero_end", 64'(ze8), 64'd1);

        for (int k = 0; k < 8; k++) begin
            xv[k*10 +: 10] = 10'd1023;
            wv[k*8 +: 8]   = 8'd255;
        end
        fexp = 64'd2086920;
        applyStimulus(1'b0, xv, wv, 4'd0, 0);
        checkOutput("max_final", 64'(final8), fexp);
        checkOutput("max_loss", 64'(loss8), fexp * fexp);
        checkOutput("max_zero_end", 64'(ze8), 64'd0);

        applyStimulus(1'b0, 80'd1, 64'd1, 4'd15, 0);
        checkOutput("neg_final", 64'(final8), 64'd1);
        checkOutput("neg_loss", 64'(loss8), 64'd196);
        checkOutput("neg_zero_end", 64'(ze8), 64'd0);

        for (int k = 0; k < 8; k++) begin
            xv[k*10 +: 10] = 10'd1;
            wv[k*8 +: 8]   = 8'd2;
        end
        @(negedge clk);
        x8 = xv; w8 = wv; t8 = 4'd3; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_final", 64'(final8), 64'd0);
        checkOutput("arst_loss", 64'(loss8), 64'd0);
        checkOutput("arst_busy", 64'(busy8), 64'd0);
        checkOutput("arst_weights", weights8, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, xv, wv, 4'd3, 0);
        checkOutput("post_rst_latency", 64'(pass_cycles), 64'd9);
        checkOutput("post_rst_final", 64'(final8), 64'd16);
        checkOutput("post_rst_loss", 64'(loss8), 64'd169);

        applyStimulus(1'b0, xv, wv, 4'd3, 3);
        checkOutput("ign_latency", 64'(pass_cycles), 64'd9);
        checkOutput("ign_final", 64'(final8), 64'd16);
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) extra++;
        end
        checkOutput("ign_no_extra_done", 64'(extra), 64'd0);

        @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        clear8 = 1'b1;
        @(negedge clk);
        clear8 = 1'b0;
        checkOutput("clr_busy", 64'(busy8), 64'd0);
        checkOutput("clr_final", 64'(final8), 64'd0);
        checkOutput("clr_loss", 64'(loss8), 64'd0);
        checkOutput("clr_zero_end", 64'(ze8), 64'd0);
        checkOutput("clr_weights_kept", weights8, wv);
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) extra++;
        end
        checkOutput("clr_no_done", 64'(extra), 64'd0);

        start8 = 1'b1;
        clear8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        clear8 = 1'b0;
        checkOutput("clr_prio_busy", 64'(busy8), 64'd0);

        xv = '0;
        wv = '0;
        for (int k = 0; k < 4; k++) begin
            xv[k*10 +: 10] = 10'(k + 1);
            wv[k*8 +: 8]   = 8'(10 * (k + 1));
        end
        applyStimulus(1'b1, xv, wv, 4'd7, 0);
        checkOutput("n4_latency", 64'(pass_cycles), 64'd5);
        checkOutput("n4_busy_len", 64'(busy_cycles), 64'd5);
        checkOutput("n4_final", 64'(final4), 64'd300);
        checkOutput("n4_loss", 64'(loss4), 64'd85849);
        checkOutput("n4_weights", 64'(weights4), 64'(wv[31:0]));

        for (int k = 0; k < 4; k++) begin
            x4[k*10 +: 10] = 10'd5;
            w4[k*8 +: 8]   = 8'd6;
        end
        t4 = 4'd0;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        cnt = 1;
        while (!done4 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("n4_period", 64'(cnt), 64'd6);
        checkOutput("n4_b2b_final", 64'(final4), 64'd120);
        checkOutput("n4_b2b_loss", 64'(loss4), 64'd14400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
